// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and operand-signedness helpers.
package muldiv_unit_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, op, a, b, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, a, b, rd_in, flush,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit_signfix.sv
// Operand magnitude extraction and result-sign flags for the current funct3.
module muldiv_unit_signfix
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_mag_a,
    output logic [XLEN-1:0] o_mag_b,
    output logic            o_neg_res,
    output logic            o_neg_rem
);
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = op_a_signed(i_op) & i_a[XLEN-1];
    assign w_b_neg = op_b_signed(i_op) & i_b[XLEN-1];

    // Negation wraps, so the most negative value maps onto itself as an unsigned magnitude.
    assign o_mag_a   = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign o_mag_b   = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign o_neg_res = w_a_neg ^ w_b_neg;
    assign o_neg_rem = w_a_neg;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// sharing one hi/lo register pair, one bit per cycle, start/busy/done handshake.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN   = MDU_XLEN,
    parameter int CYCLES = MDU_XLEN
) (
    input logic         clk,
    input logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int                CNT_W    = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

    mdu_state_e      r_state;
    logic [2:0]      r_op;
    logic [4:0]      r_rd_cap;
    logic [4:0]      r_rd_out;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opnd;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic [CNT_W-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg_res;
    logic              w_neg_rem;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_result;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shifted;
    logic [XLEN:0]     w_diff;
    logic              w_borrow;
    logic [XLEN-1:0]   w_hi_n;
    logic [XLEN-1:0]   w_lo_n;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_final;

    muldiv_unit_signfix #(.XLEN(XLEN)) u_signfix (
        .i_op      (bus.op),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .o_mag_a   (w_mag_a),
        .o_mag_b   (w_mag_b),
        .o_neg_res (w_neg_res),
        .o_neg_rem (w_neg_rem)
    );

    assign w_div0    = bus.op[2] && (bus.b == '0);
    assign w_ovf     = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
                       (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
    assign w_special = w_div0 || w_ovf;

    always_comb begin
        w_spec_result = '0;
        if (w_div0)
            w_spec_result = bus.op[1] ? bus.a : '1;
        else if (w_ovf)
            w_spec_result = bus.op[1] ? '0 : bus.a;
    end

    // Multiply: hi accumulates the multiplicand when the multiplier LSB (in lo) is set,
    // then {carry, hi, lo} shifts right by one.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide: the 33-bit difference is negative exactly when the shifted remainder
    // is smaller than the divisor, so its MSB serves as the borrow.
    assign w_shifted = {r_hi, r_lo[XLEN-1]};
    assign w_diff    = w_shifted - {1'b0, r_opnd};
    assign w_borrow  = w_diff[XLEN];

    always_comb begin
        w_hi_n = w_sum[XLEN:1];
        w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
        if (r_op[2]) begin
            w_hi_n = w_borrow ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], ~w_borrow};
        end
    end

    assign w_prod_fix = r_neg_res ? (~{w_hi_n, w_lo_n} + 1'b1) : {w_hi_n, w_lo_n};
    assign w_quo_fix  = r_neg_res ? (~w_lo_n + 1'b1) : w_lo_n;
    assign w_rem_fix  = r_neg_rem ? (~w_hi_n + 1'b1) : w_hi_n;

    always_comb begin
        w_final = '0;
        case (r_op)
            MDU_MUL:                          w_final = w_prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_final = w_prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                w_final = w_quo_fix;
            MDU_REM, MDU_REMU:                w_final = w_rem_fix;
            default:                          w_final = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_rd_cap  <= '0;
            r_rd_out  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.op;
                        r_rd_cap  <= bus.rd_in;
                        r_hi      <= '0;
                        r_lo      <= w_mag_a;
                        r_opnd    <= w_mag_b;
                        r_neg_res <= w_neg_res;
                        r_neg_rem <= w_neg_rem;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_special) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_spec_result;
                            r_rd_out <= bus.rd_in;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt + 1'b1;
                    // Last iteration and sign fix-up land on the same edge.
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_final;
                        r_rd_out <= r_rd_cap;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit plus flush and async-reset sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 20;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    vec_t vecs[NVEC];

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        lat = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.rd_in = v.rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
        bus.rd_in = 5'd30;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'(v.lat));
        chk({name, " result"}, bus.result, v.exp);
        chk({name, " rd_out"}, 32'(bus.rd_out), 32'(v.rd));
        chk({name, " busy in done"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk({name, " done one cycle"}, 32'({bus.done, bus.busy}), 32'd0);
        chk({name, " result held"}, bus.result, v.exp);
    endtask

    initial begin
        bit saw_done;
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{MDU_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 33};
        vecs[2]  = '{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
        vecs[3]  = '{MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{MDU_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{MDU_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{MDU_DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        33};
        vecs[7]  = '{MDU_REMU,   32'd100,        32'd7,         5'd8,  32'd2,         33};
        vecs[8]  = '{MDU_DIVU,   32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{MDU_REM,    32'd5,          32'd0,         5'd10, 32'd5,         1};
        vecs[10] = '{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
        vecs[12] = '{MDU_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd13, 32'd1,         33};
        vecs[13] = '{MDU_DIV,    32'd7,          32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33};
        vecs[14] = '{MDU_REM,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFF, 33};
        vecs[15] = '{MDU_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd31, 32'd0,         33};
        vecs[16] = '{MDU_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 33};
        vecs[17] = '{MDU_DIV,    32'h8000_0000,  32'd1,         5'd17, 32'h8000_0000, 33};
        vecs[18] = '{MDU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd18, 32'd0,         33};
        vecs[19] = '{MDU_DIV,    32'd5,          32'd0,         5'd19, 32'hFFFF_FFFF, 1};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.rd_in = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset rd_out", 32'(bus.rd_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // In-flight MUL: ignored start at cycle 10, flush at cycle 20.
        saw_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        bus.rd_in = 5'd20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
            if (k == 10) begin
                bus.start = 1'b1;
                bus.op    = MDU_DIVU;
                bus.a     = 32'd1;
                bus.b     = 32'd0;
            end
            if (k == 11) bus.start = 1'b0;
        end
        chk("busy before flush", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush busy", 32'(bus.busy), 32'd0);
        chk("flush done", 32'(bus.done), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("flush no done", 32'(saw_done), 32'd0);
        chk("flush result held", bus.result, vecs[NVEC-1].exp);
        chk("flush rd held", 32'(bus.rd_out), 32'(vecs[NVEC-1].rd));

        // flush beats start in the same IDLE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = MDU_DIVU;
        bus.a     = 32'd1;
        bus.b     = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush over start", 32'({bus.busy, bus.done}), 32'd0);

        run_vec('{MDU_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 33}, "divu after flush");

        // Async reset in the middle of a DIV.
        saw_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.rd_in = 5'd22;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst busy", 32'(bus.busy), 32'd0);
        chk("async rst done", 32'(bus.done), 32'd0);
        chk("async rst result", bus.result, 32'd0);
        chk("async rst rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("rst no done", 32'(saw_done), 32'd0);
        chk("rst idle busy", 32'(bus.busy), 32'd0);

        run_vec(vecs[0], "mul after rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
